// File: rtl/hockey_core.sv
// Air-hockey game controller: serve, puck travel with wall reflection, response
// windows, scoring and game-over sequencing on a configurable field.
module hockey_core #(
  parameter int X_W        = 3,
  parameter int X_LAST     = 7,
  parameter int Y_W        = 3,
  parameter int Y_LAST     = 4,
  parameter int SCORE_W    = 2,
  parameter int WIN_SCORE  = 3,
  parameter int TICK_W     = 4,
  parameter int SHOW_TICKS = 2,
  parameter int STEP_TICKS = 2,
  parameter int MIN_STEP   = 1,
  parameter int RESP_TICKS = 2,
  parameter int STRICT     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               BTN_A,
  input  logic               BTN_B,
  input  logic [1:0]         DIR_A,
  input  logic [1:0]         DIR_B,
  input  logic [Y_W-1:0]     Y_in_A,
  input  logic [Y_W-1:0]     Y_in_B,
  output logic [X_W-1:0]     X_COORD,
  output logic [Y_W-1:0]     Y_COORD,
  output logic [SCORE_W-1:0] score_A,
  output logic [SCORE_W-1:0] score_B,
  output logic [3:0]         state_o,
  output logic [1:0]         winner,
  output logic [7:0]         rally
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_DISP   = 4'd1;
  localparam logic [3:0] S_HIT_A  = 4'd2;
  localparam logic [3:0] S_HIT_B  = 4'd3;
  localparam logic [3:0] S_SEND_A = 4'd4;
  localparam logic [3:0] S_SEND_B = 4'd5;
  localparam logic [3:0] S_RESP_A = 4'd6;
  localparam logic [3:0] S_RESP_B = 4'd7;
  localparam logic [3:0] S_GOAL_A = 4'd8;
  localparam logic [3:0] S_GOAL_B = 4'd9;
  localparam logic [3:0] S_OVER   = 4'd10;

  localparam logic [1:0] D_STR = 2'b00;
  localparam logic [1:0] D_UP  = 2'b01;
  localparam logic [1:0] D_DN  = 2'b10;

  localparam logic [X_W-1:0]     X_MAX     = X_W'(X_LAST);
  localparam logic [Y_W-1:0]     Y_MAX     = Y_W'(Y_LAST);
  localparam logic [SCORE_W-1:0] WIN_V     = SCORE_W'(WIN_SCORE);
  localparam logic [TICK_W-1:0]  SHOW_M1   = TICK_W'(SHOW_TICKS - 1);
  localparam logic [TICK_W-1:0]  RESP_M1   = TICK_W'(RESP_TICKS - 1);
  localparam logic [TICK_W-1:0]  STEP_V    = TICK_W'(STEP_TICKS);
  localparam logic [TICK_W-1:0]  MIN_V     = TICK_W'(MIN_STEP);
  localparam bit                 STRICT_ON = (STRICT != 0);

  logic [3:0]         state_q, state_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [1:0]         dir_q, dir_d;
  logic [SCORE_W-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [1:0]         win_q, win_d;
  logic [7:0]         rally_q, rally_d;
  logic [TICK_W-1:0]  timer_q, timer_d;
  logic [TICK_W-1:0]  step_q, step_d;
  logic               start_b_q, start_b_d;

  logic               show_done, step_done, resp_done;
  logic [7:0]         rally_inc;
  logic [TICK_W-1:0]  step_dec;

  function automatic logic [1:0] norm_dir(input logic [1:0] d);
    return (d == 2'b11) ? D_STR : d;
  endfunction

  // Returns {new_dir, new_y}; bounces off the top and bottom walls.
  function automatic logic [Y_W+1:0] reflect(input logic [Y_W-1:0] y, input logic [1:0] d);
    logic [Y_W+1:0] r;
    r = {d, y};
    if (d == D_UP)      r = (y == Y_MAX) ? {D_DN, y - 1'b1} : {D_UP, y + 1'b1};
    else if (d == D_DN) r = (y == '0)    ? {D_UP, y + 1'b1} : {D_DN, y - 1'b1};
    return r;
  endfunction

  assign show_done = tick && (timer_q == SHOW_M1);
  assign step_done = tick && (timer_q == step_q - 1'b1);
  assign resp_done = tick && (timer_q == RESP_M1);
  assign rally_inc = (rally_q == 8'hFF) ? rally_q : rally_q + 8'd1;
  assign step_dec  = (step_q > MIN_V) ? step_q - 1'b1 : step_q;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    win_d     = win_q;
    rally_d   = rally_q;
    step_d    = step_q;
    start_b_d = start_b_q;
    timer_d   = tick ? timer_q + 1'b1 : timer_q;
    case (state_q)
      S_IDLE: if (BTN_A || BTN_B) begin
        sa_d      = '0;
        sb_d      = '0;
        win_d     = '0;
        rally_d   = '0;
        start_b_d = !BTN_A;
        state_d   = S_DISP;
      end
      S_DISP: if (show_done) state_d = start_b_q ? S_HIT_B : S_HIT_A;
      S_HIT_A: if (BTN_A && (Y_in_A <= Y_MAX)) begin
        x_d     = '0;
        y_d     = Y_in_A;
        dir_d   = norm_dir(DIR_A);
        rally_d = '0;
        step_d  = STEP_V;
        state_d = S_SEND_B;
      end
      S_HIT_B: if (BTN_B && (Y_in_B <= Y_MAX)) begin
        x_d     = X_MAX;
        y_d     = Y_in_B;
        dir_d   = norm_dir(DIR_B);
        rally_d = '0;
        step_d  = STEP_V;
        state_d = S_SEND_A;
      end
      S_SEND_B: if (step_done) begin
        {dir_d, y_d} = reflect(y_q, dir_q);
        x_d          = x_q + 1'b1;
        timer_d      = '0;
        if (x_d == X_MAX) state_d = S_RESP_B;
      end
      S_SEND_A: if (step_done) begin
        {dir_d, y_d} = reflect(y_q, dir_q);
        x_d          = x_q - 1'b1;
        timer_d      = '0;
        if (x_d == '0) state_d = S_RESP_A;
      end
      // A matching press wins even on the expiring tick.
      S_RESP_B: begin
        if (BTN_B && (Y_in_B == y_q)) begin
          x_d          = X_MAX - 1'b1;
          {dir_d, y_d} = reflect(y_q, norm_dir(DIR_B));
          rally_d      = rally_inc;
          step_d       = step_dec;
          state_d      = S_SEND_A;
        end else if ((STRICT_ON && BTN_B) || resp_done) begin
          sa_d    = sa_q + 1'b1;
          state_d = S_GOAL_A;
        end
      end
      S_RESP_A: begin
        if (BTN_A && (Y_in_A == y_q)) begin
          x_d          = X_W'(1);
          {dir_d, y_d} = reflect(y_q, norm_dir(DIR_A));
          rally_d      = rally_inc;
          step_d       = step_dec;
          state_d      = S_SEND_B;
        end else if ((STRICT_ON && BTN_A) || resp_done) begin
          sb_d    = sb_q + 1'b1;
          state_d = S_GOAL_B;
        end
      end
      S_GOAL_A: if (show_done) begin
        if (sa_q == WIN_V) begin
          win_d   = 2'b01;
          state_d = S_OVER;
        end else begin
          state_d = S_HIT_B;
        end
      end
      S_GOAL_B: if (show_done) begin
        if (sb_q == WIN_V) begin
          win_d   = 2'b10;
          state_d = S_OVER;
        end else begin
          state_d = S_HIT_A;
        end
      end
      S_OVER: if (show_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      dir_q     <= '0;
      sa_q      <= '0;
      sb_q      <= '0;
      win_q     <= '0;
      rally_q   <= '0;
      timer_q   <= '0;
      step_q    <= STEP_V;
      start_b_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      win_q     <= win_d;
      rally_q   <= rally_d;
      timer_q   <= timer_d;
      step_q    <= step_d;
      start_b_q <= start_b_d;
    end
  end

  assign X_COORD = x_q;
  assign Y_COORD = y_q;
  assign score_A = sa_q;
  assign score_B = sb_q;
  assign state_o = state_q;
  assign winner  = win_q;
  assign rally   = rally_q;

endmodule

// File: doc/hockey_core.md
# hockey_core

Parametrised air-hockey game controller: serve, puck travel with wall reflection, response windows, scoring and game-over sequencing for two players on an X_LAST+1 by Y_LAST+1 field. It replaces the fixed 8x5 first-generation controller. New behaviour:

- configurable field, win score and dwell times;
- a tick-driven time base;
- per-rally puck speed-up and a rally counter;
- a strict-miss mode.

It sits between the debounced button/switch front end and the LED/SSD display driver.

## Interface

**Parameters**

- X_W, 3: X coordinate width.
- X_LAST, 7: last X column; must be ≥ 2 and < 2^X_W.
- Y_W, 3: Y coordinate width.
- Y_LAST, 4: last Y row; must be ≥ 1 and < 2^Y_W.
- SCORE_W, 2: score width.
- WIN_SCORE, 3: score that ends the game; must be ≥ 1 and < 2^SCORE_W.
- TICK_W, 4: width of the tick timer and step counter.
- SHOW_TICKS, 2: dwell in DISPLAY, GOAL_A, GOAL_B and GAME_OVER, in ticks.
- STEP_TICKS, 2: initial ticks per puck step.
- MIN_STEP, 1: fastest ticks per step; must be ≥ 1.
- RESP_TICKS, 2: length of the response window, in ticks.
- STRICT, 0: 1 = a response press with the wrong Y is an immediate miss.

**Ports**

- clk, input, 1: sole clock, rising edge.
- rst, input, 1: synchronous, active-low reset.
- tick, input, 1: one-cycle time-base strobe.
- BTN_A, BTN_B, input, 1: single-cycle debounced press pulses.
- DIR_A, DIR_B, input, 2: 00 straight, 01 up (+Y), 10 down (−Y), 11 treated as 00.
- Y_in_A, Y_in_B, input, Y_W: paddle row.
- X_COORD, output, X_W: puck column.
- Y_COORD, output, Y_W: puck row.
- score_A, score_B, output, SCORE_W: scores.
- state_o, output, 4: state code.
- winner, output, 2: 00 none, 01 A, 10 B.
- rally, output, 8: returns in the current point; saturates at 255.

## Operation

**State codes:** IDLE=0, DISPLAY=1, HIT_A=2, HIT_B=3, SEND_A=4 (puck toward A, X decreasing), SEND_B=5, RESP_A=6, RESP_B=7, GOAL_A=8 (A scored), GOAL_B=9, GAME_OVER=10. Unused codes go to IDLE.

**Reset.** When rst=0 at a clk edge:

- state IDLE;
- X_COORD, Y_COORD, score_A, score_B, winner, rally, timer and dir all 0;
- cur_step = STEP_TICKS.

**IDLE.** A press of BTN_A or BTN_B clears scores, winner and rally, records the starter, and moves to DISPLAY. If both are pressed in the same cycle, A starts.

**DISPLAY.** Dwell SHOW_TICKS ticks, then go to HIT of the starter.

**HIT_A (serve).** BTN_A with Y_in_A ≤ Y_LAST:

- X=0, Y=Y_in_A, dir=DIR_A;
- rally=0, cur_step=STEP_TICKS, timer=0;
- go to SEND_B.

A press with Y_in_A > Y_LAST is ignored. HIT_B mirrors this with X=X_LAST and a transition to SEND_A.

**SEND_x.** Each cur_step ticks, one puck step:

- Y reflect rule:
  - dir up and Y==Y_LAST: dir becomes down, Y−1.
  - dir down and Y==0: dir becomes up, Y+1.
  - dir up (otherwise): Y+1.
  - dir down (otherwise): Y−1.
  - straight: Y unchanged.
- SEND_B: X+1. When the new X equals X_LAST, go to RESP_B with timer=0.
- SEND_A: X−1. When the new X equals 0, go to RESP_A with timer=0.

**RESP_B.** A valid return is BTN_B with Y_in_B==Y_COORD before RESP_TICKS ticks have elapsed. On a valid return:

- X=X_LAST−1, dir=DIR_B, and one immediate Y step by the reflect rule;
- rally+1 (saturating);
- cur_step−1 if cur_step > MIN_STEP;
- timer=0; go to SEND_A.

A miss is either the window expiring, or (STRICT=1 only) a BTN_B press with the wrong Y. On a miss: score_A+1, go to GOAL_A. RESP_A mirrors this: X=1, dir=DIR_A, transition to SEND_B, a miss gives score_B+1 and GOAL_B.

**GOAL_A.** Dwell SHOW_TICKS ticks. Then:

- score_A==WIN_SCORE: winner=01, go to GAME_OVER.
- otherwise: go to HIT_B (the conceding player serves).

GOAL_B mirrors this (winner=10, HIT_A).

**GAME_OVER.** Dwell SHOW_TICKS ticks, then go to IDLE. Scores and winner hold until the next start.

**Arithmetic.** Scores never exceed WIN_SCORE, so no wrap occurs. Coordinates stay in range by construction.

## Timing

- All outputs are registered and update on the clk edge following the cause. state_o equals the current state register.
- Dwell rule: the timer counts only on tick=1. A state with dwell N exits at the edge where tick=1 and timer==N−1, so it lasts exactly N ticks. The timer clears on every state change.
- Buttons are sampled every cycle, independent of tick.
- In RESP, a valid press in the same cycle as the expiring tick counts as a return.
- Buttons pressed in any state other than IDLE, HIT and RESP are ignored.
- A rst=0 edge aborts any state immediately to the reset values. There is no partial-point retention.

## Test plan

Defaults unless stated: X_LAST=7, Y_LAST=4, tick every cycle.

1. **Serve and travel.** Reset, BTN_A, wait 2 ticks, then BTN_A with Y_in_A=2, DIR_A=01. Required:
   - Puck (X,Y) sequence: (0,2), (1,3), (2,4), (3,3), (4,2), (5,1), (6,0), (7,1).
   - 2 ticks per step.
   - state goes to RESP_B after 14 ticks.
2. **Miss.** In RESP_B, no press for 2 ticks. Required: score_A=1, state GOAL_A, then HIT_B after 2 ticks.
3. **Return and speed-up.** In RESP_B, BTN_B with Y_in_B==Y_COORD and DIR_B=10. Required: X=6, Y−1, rally=1, subsequent steps every 1 tick, state SEND_A.
4. **Strict mode.** STRICT=1, in RESP_A press BTN_A with a mismatched Y. Required: score_B+1 on the next edge. With STRICT=0 the same press is ignored.
5. **Game over.** Three A goals. Required: winner=01, GAME_OVER for 2 ticks, then IDLE with score_A held at 3; the next BTN_B clears scores.
6. **Mid-point reset and simultaneous start.** rst=0 during SEND_A. Required: X=0, Y=0, scores 0, state IDLE next edge. Then BTN_A and BTN_B pressed together in IDLE. Required: A starts (serve in HIT_A).
